// File: rtl/seq_restoring_divider_pkg.sv
// Shared widths, state encoding and sizing helper for the restoring divider
// and any future unrolled divider built from the same step cell.
package div_pkg;

  localparam int DEFAULT_DIVIDEND_W = 8;
  localparam int DEFAULT_DIVISOR_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_e;

  // Counter must be able to hold the iteration count itself.
  function automatic int cnt_width(input int iterations);
    return $clog2(iterations + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_DIVIDEND_W);

endpackage

// File: rtl/seq_restoring_divider_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only when no borrow occurs.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DEFAULT_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   partial_in,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   partial_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] trial;
  logic               unused_partial_msb;

  // partial_in < divisor always, so its MSB is zero and the shifted value
  // fits DIVISOR_W+1 bits; the borrow is then the MSB of the difference.
  always_comb begin
    shifted     = {partial_in[DIVISOR_W-1:0], dividend_bit};
    trial       = shifted - {1'b0, divisor};
    q_bit       = ~trial[DIVISOR_W];
    partial_out = q_bit ? trial : shifted;
  end

  assign unused_partial_msb = partial_in[DIVISOR_W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Results are shadowed so the outputs only change on completion.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEFAULT_DIVIDEND_W,
  parameter int DIVISOR_W  = DEFAULT_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int              CNT_W     = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  div_state_e            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dbz_q, dbz_d;
  logic [DIVIDEND_W-1:0] work_q, work_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic [DIVISOR_W:0]    partial_q, partial_d;
  logic [DIVISOR_W:0]    step_partial;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  step_q_bit;

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .partial_in  (partial_q),
    .dividend_bit(work_q[DIVIDEND_W-1]),
    .divisor     (divisor_q),
    .partial_out (step_partial),
    .q_bit       (step_q_bit)
  );

  // work_q doubles as dividend shifter and quotient accumulator: the dividend
  // MSB leaves at the top while each new quotient bit enters at the bottom.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    divisor_d   = divisor_q;
    partial_d   = partial_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          work_d    = dividend;
          divisor_d = divisor;
          partial_d = '0;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          if (divisor != '0) begin
            state_d = RUN;
          end else begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        partial_d = step_partial;
        work_d    = {work_q[DIVIDEND_W-2:0], step_q_bit};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d     = DONE;
          quotient_d  = {work_q[DIVIDEND_W-2:0], step_q_bit};
          remainder_d = step_partial[DIVISOR_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      work_q      <= '0;
      quotient_q  <= '0;
      divisor_q   <= '0;
      remainder_q <= '0;
      partial_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      work_q      <= work_d;
      quotient_q  <= quotient_d;
      divisor_q   <= divisor_d;
      remainder_q <= remainder_d;
      partial_q   <= partial_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
